pw_conv_post_process: RTL and testbench

Reassembles the half-vector stream produced by the pointwise-conv time-multiplexing stage back into full-width channel vectors. Accepts one IN_CHANNEL-wide half per handshake, lower half (channels 0..IN_CHANNEL-1) first and upper half second. Emits one OUT_CHANNEL-wide word per completed pair through a registered valid/ready output. Sits after the PW conv datapath, feeding the full-width writeback/next-layer path.

---
 rtl/pw_conv_post_process.sv | 114 +++++++++++
 tb/tb_pw_conv_post_process.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pw_conv_post_process.sv
// pw_conv_post_process
// Reassembles lower/upper half-vector beats from the pointwise-conv
// time-multiplexing stage into full-width channel words behind a registered
// valid/ready output.
// Optional build macro: PW_POST_PHASE_CHECK_EN enables in_half tag checking
// with sync_err pulse and saturating err_cnt; without it in_half is ignored.
module pw_conv_post_process #(
    parameter int DATA_WIDTH  = 8,
    parameter int IN_CHANNEL  = 9,
    parameter int OUT_CHANNEL = 18,
    parameter int HALF_WIDTH  = DATA_WIDTH * IN_CHANNEL,
    parameter int FULL_WIDTH  = DATA_WIDTH * OUT_CHANNEL
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_half,
    input  logic [HALF_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FULL_WIDTH-1:0] out_data,
    output logic                  sync_err,
    output logic [7:0]            err_cnt
);

    if (OUT_CHANNEL != 2 * IN_CHANNEL) begin : g_bad_width
        $error("pw_conv_post_process: OUT_CHANNEL must equal 2*IN_CHANNEL");
    end

    typedef enum logic {LOW_WAIT, HIGH_WAIT} state_t;

    state_t                state, state_nxt;
    logic [HALF_WIDTH-1:0] lo_reg;
    logic                  accept;
    logic                  mismatch;
    logic                  lo_load;
    logic                  word_load;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= LOW_WAIT;
        else       state <= state_nxt;
    end

    // Handshake, tag check and next-state decode
    always_comb begin
        state_nxt = state;
        lo_load   = 1'b0;
        word_load = 1'b0;
        mismatch  = 1'b0;
        in_ready  = (state == LOW_WAIT) ? 1'b1 : (!out_valid || out_ready);
        accept    = in_valid && in_ready && !clear;
`ifdef PW_POST_PHASE_CHECK_EN
        mismatch  = accept && ((state == LOW_WAIT) ? in_half : !in_half);
`endif
        if (clear) begin
            state_nxt = LOW_WAIT;
        end else if (accept && !mismatch) begin
            if (state == LOW_WAIT) begin
                lo_load   = 1'b1;
                state_nxt = HIGH_WAIT;
            end else begin
                word_load = 1'b1;
                state_nxt = LOW_WAIT;
            end
        end else if (mismatch && state == HIGH_WAIT) begin
            // Lower-tagged beat while waiting for upper: resync on it.
            lo_load = 1'b1;
        end
    end

    // Lower-half holding register and registered output word
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lo_reg    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else begin
            if (lo_load) lo_reg <= in_data;
            if (word_load) begin
                out_data  <= {in_data, lo_reg};
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef PW_POST_PHASE_CHECK_EN
    // Tag-mismatch pulse and saturating error counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_err <= 1'b0;
            err_cnt  <= '0;
        end else if (clear) begin
            sync_err <= 1'b0;
            err_cnt  <= '0;
        end else begin
            sync_err <= mismatch;
            if (mismatch && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    logic unused_half;
    assign unused_half = in_half;
    assign sync_err    = 1'b0;
    assign err_cnt     = '0;
`endif

endmodule

// File: tb/tb_pw_conv_post_process.sv
// Self-checking bench for pw_conv_post_process: directed scenarios plus a
// randomized stream, all checked against a queue-based pairing model.
module tb_pw_conv_post_process;

    localparam int HW = 72;
    localparam int FW = 144;
`ifdef PW_POST_PHASE_CHECK_EN
    localparam bit PHASE = 1'b1;
`else
    localparam bit PHASE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn, clear, in_valid, in_half, out_ready;
    logic [HW-1:0] in_data;
    logic          in_ready, out_valid, sync_err;
    logic [FW-1:0] out_data;
    logic [7:0]    err_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: accepted halves waiting for a partner, words waiting
    // to be popped, the most recently formed word, and error bookkeeping.
    logic [HW-1:0] half_q[$];
    logic [FW-1:0] word_q[$];
    logic [FW-1:0] last_word;
    int            err_m;
    logic          sync_m;

    pw_conv_post_process #(
        .DATA_WIDTH (8),
        .IN_CHANNEL (9),
        .OUT_CHANNEL(18)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_half  (in_half),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .sync_err (sync_err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("out_valid", FW'(out_valid), FW'(word_q.size() != 0));
        check("out_data", out_data, last_word);
        check("sync_err", FW'(sync_err), FW'(sync_m));
        check("err_cnt", FW'(err_cnt), FW'(err_m));
    endtask

    // One clock: drive inputs, check in_ready, advance model, check outputs.
    task automatic cycle(input logic v, input logic h, input logic [HW-1:0] d,
                         input logic ordy, input logic clr);
        logic rdy_m, acc, mism;
        in_valid = v; in_half = h; in_data = d; out_ready = ordy; clear = clr;
        #1;
        rdy_m = (half_q.size() == 0) || (word_q.size() == 0) || ordy;
        check("in_ready", FW'(in_ready), FW'(rdy_m));
        acc = v && rdy_m && !clr;
        @(posedge clk);
        #1;
        sync_m = 1'b0;
        if (clr) begin
            half_q.delete();
            word_q.delete();
            err_m = 0;
        end else begin
            if (word_q.size() != 0 && ordy) void'(word_q.pop_front());
            if (acc) begin
                mism = PHASE && (h != (half_q.size() != 0));
                if (mism) begin
                    sync_m = 1'b1;
                    if (err_m < 255) err_m++;
                    if (half_q.size() != 0) half_q[0] = d;
                end else begin
                    half_q.push_back(d);
                    if (half_q.size() == 2) begin
                        last_word = {half_q[1], half_q[0]};
                        word_q.push_back(last_word);
                        half_q.delete();
                    end
                end
            end
        end
        check_outputs();
    endtask

    function automatic logic [HW-1:0] rnd72();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[HW-1:0];
    endfunction

    function automatic logic tag_m();
        return half_q.size() != 0;
    endfunction

    initial begin
        logic [HW-1:0] d;
        logic v, r;
        rstn = 1'b0; clear = 1'b0; in_valid = 1'b0; in_half = 1'b0;
        in_data = '0; out_ready = 1'b0;
        last_word = '0; err_m = 0; sync_m = 1'b0;
        @(posedge clk);
        #1;
        check("reset_in_ready", FW'(in_ready), FW'(1));
        check_outputs();
        rstn = 1'b1;

        // Basic pair with the documented byte pattern
        d = 72'h090807060504030201;
        cycle(1'b1, 1'b0, d, 1'b1, 1'b0);
        d = 72'h1211100F0E0D0C0B0A;
        cycle(1'b1, 1'b1, d, 1'b1, 1'b0);
        check("pair_word", out_data, 144'h1211100F0E0D0C0B0A_090807060504030201);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Continuous stream of 8 beats with out_ready held high
        for (int i = 0; i < 8; i++) cycle(1'b1, tag_m(), rnd72(), 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Stall: word pending, lower accepted, upper blocked, then pop+load
        cycle(1'b1, 1'b0, rnd72(), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, rnd72(), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, rnd72(), 1'b0, 1'b0);
        d = rnd72();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, d, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, d, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Clear after a lower half: next beat is a fresh lower half
        cycle(1'b1, 1'b0, rnd72(), 1'b1, 1'b0);
        cycle(1'b1, 1'b1, rnd72(), 1'b1, 1'b1);
        cycle(1'b1, 1'b0, rnd72(), 1'b1, 1'b0);
        cycle(1'b1, 1'b1, rnd72(), 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

`ifdef PW_POST_PHASE_CHECK_EN
        // Upper-tagged beat in LOW_WAIT: dropped, pulse, count
        cycle(1'b1, 1'b1, rnd72(), 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        // Lower-tagged beat in HIGH_WAIT: resync lower half
        cycle(1'b1, 1'b0, rnd72(), 1'b1, 1'b0);
        cycle(1'b1, 1'b0, rnd72(), 1'b1, 1'b0);
        cycle(1'b1, 1'b1, rnd72(), 1'b1, 1'b0);
        // Saturation
        for (int i = 0; i < 260; i++) cycle(1'b1, 1'b1, rnd72(), 1'b1, 1'b0);
        check("err_sat", FW'(err_cnt), FW'(255));
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
`endif

        // Randomized traffic with random backpressure and occasional clear
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            if (PHASE && $urandom_range(0, 15) == 0)
                cycle(v, ~tag_m(), rnd72(), r, ($urandom_range(0, 31) == 0));
            else
                cycle(v, tag_m(), rnd72(), r, ($urandom_range(0, 31) == 0));
        end

        // Reset while a word is pending and a lower half is held
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, rnd72(), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, rnd72(), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, rnd72(), 1'b0, 1'b0);
        rstn = 1'b0;
        in_valid = 1'b0;
        #1;
        half_q.delete(); word_q.delete();
        last_word = '0; err_m = 0; sync_m = 1'b0;
        check("rst_in_ready", FW'(in_ready), FW'(1));
        check_outputs();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        d = rnd72();
        cycle(1'b1, 1'b0, d, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, rnd72(), 1'b1, 1'b0);
        check("post_rst_lo", FW'(out_data[HW-1:0]), FW'(d));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
